exec_req_initiator: RTL and testbench

//  Request-side initiator for execution_unit: accepts host commands, tags each with a free 3-bit req_id,

---
 rtl/exec_req_initiator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_exec_req_initiator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_req_initiator.sv
// ---------------------------------------------------------------------------
// exec_req_initiator
//
// Request-side initiator for execution_unit. Host commands are tagged with
// the lowest free 3-bit ID (1..7; 0 is the idle rsp_id), parked in a single
// pending slot and issued as input_req whenever execution_unit's FIFO is not
// full. Responses from output_rsp are checked against a busy-ID scoreboard
// and turned into one-cycle completions carrying the op type stored at issue.
//
// Optional feature macro: EXEC_REQ_TIMEOUT_EN
//   defined   : per-ID age counters force-free an ID after TIMEOUT_CYCLES
//               busy cycles and set the sticky err_timeout flag.
//   undefined : no counters, err_timeout is tied low.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready host command handshake
//   cmd_type            0 = add, 1 = mul
//   cmd_data1/2         operands (DATA_W)
//   flush               stop accepting and drain all outstanding IDs
//   fifo_full           backpressure from execution_unit
//   input_req           request packet to execution_unit
//   output_rsp          response packet from execution_unit
//   cpl_valid/id/type/data  one-cycle completion strobe to the host
//   outstanding         registered count of busy IDs
//   drained             in DRAIN with nothing outstanding
//   err_unexp           sticky: response for ID 0 or a non-busy ID
//   err_timeout         sticky: an ID aged out (timeout build only)
// ---------------------------------------------------------------------------
package exec_req_pkg;
  localparam int PKT_DATA_W = 32;

  typedef struct packed {
    logic                  req;
    logic                  req_type;
    logic [2:0]            req_id;
    logic [PKT_DATA_W-1:0] req_data1;
    logic [PKT_DATA_W-1:0] req_data2;
  } req_pkt_type;

  typedef struct packed {
    logic                    rsp;
    logic [2:0]              rsp_id;
    logic [2*PKT_DATA_W-1:0] rsp_data;
  } rsp_pkt_type;
endpackage

module exec_req_initiator
  import exec_req_pkg::*;
#(
  parameter int DATA_W         = PKT_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_type,
  input  logic [DATA_W-1:0]   cmd_data1,
  input  logic [DATA_W-1:0]   cmd_data2,
  input  logic                flush,
  input  logic                fifo_full,
  output req_pkt_type         input_req,
  input  rsp_pkt_type         output_rsp,
  output logic                cpl_valid,
  output logic [2:0]          cpl_id,
  output logic                cpl_type,
  output logic [2*DATA_W-1:0] cpl_data,
  output logic [2:0]          outstanding,
  output logic                drained,
  output logic                err_unexp,
  output logic                err_timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Bit 0 of the per-ID vectors is never set: ID 0 is reserved.
  logic [7:0] busy_q, busy_d;
  logic [7:0] type_q, type_d;
  logic [7:0] expire;

  logic              pend_valid_q, pend_valid_d;
  logic              pend_type_q, pend_type_d;
  logic [2:0]        pend_id_q, pend_id_d;
  logic [DATA_W-1:0] pend_data1_q, pend_data1_d;
  logic [DATA_W-1:0] pend_data2_q, pend_data2_d;

  logic [2:0]          outstanding_q, outstanding_d;
  logic                cpl_valid_q, cpl_valid_d;
  logic [2:0]          cpl_id_q, cpl_id_d;
  logic                cpl_type_q, cpl_type_d;
  logic [2*DATA_W-1:0] cpl_data_q, cpl_data_d;
  logic                err_unexp_q, err_unexp_d;
  logic                err_timeout_q, err_timeout_d;

  logic [2:0] alloc_id;
  logic       any_free;
  logic       issue;
  logic       accept;
  logic       rsp_hit;

  // Lowest free ID, taken from the registered busy vector so an ID retired
  // this cycle only becomes allocatable on the next one.
  always_comb begin
    alloc_id = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (!busy_q[i]) alloc_id = 3'(i);
    end
  end

  assign any_free  = ~&busy_q[7:1];
  assign issue     = pend_valid_q && !fifo_full && !rst;
  // The slot may be refilled in the same cycle it issues.
  assign cmd_ready = !rst && (state_q == S_IDLE) && !flush && any_free &&
                     (!pend_valid_q || !fifo_full);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_hit   = output_rsp.rsp && (output_rsp.rsp_id != 3'd0) &&
                     busy_q[output_rsp.rsp_id];

  // Per-ID scoreboard: a retirement (response or timeout) clears the bit,
  // allocation sets it. Both never target the same ID in one cycle since
  // allocation only picks IDs that are currently free.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_id
      logic clr;
      assign clr        = (rsp_hit && (output_rsp.rsp_id == 3'(gi))) || expire[gi];
      assign busy_d[gi] = (accept && (alloc_id == 3'(gi))) || (busy_q[gi] && !clr);
      assign type_d[gi] = (accept && (alloc_id == 3'(gi))) ? cmd_type : type_q[gi];
    end
  endgenerate
  assign busy_d[0] = 1'b0;
  assign type_d[0] = 1'b0;

`ifdef EXEC_REQ_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  generate
    for (gi = 1; gi < 8; gi++) begin : g_age
      logic [AGE_W-1:0] age_q, age_d;

      always_comb begin
        age_d = age_q;
        if (accept && (alloc_id == 3'(gi))) age_d = '0;
        else if (busy_q[gi])                age_d = age_q + 1'b1;
      end

      // Expires on the edge at which the age would reach TIMEOUT_CYCLES;
      // a response arriving in that same cycle wins and completes normally.
      assign expire[gi] = busy_q[gi] &&
                          (age_q == AGE_W'(TIMEOUT_CYCLES - 1)) &&
                          !(rsp_hit && (output_rsp.rsp_id == 3'(gi)));

      always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
      end
    end
  endgenerate
  assign expire[0] = 1'b0;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire         = '0;
`endif

  // Outstanding mirrors the next busy vector, so it already reflects
  // +accept and -retire of this cycle once registered.
  always_comb begin
    outstanding_d = 3'd0;
    for (int i = 1; i < 8; i++) begin
      outstanding_d = outstanding_d + {2'b00, busy_d[i]};
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;
    pend_id_d    = pend_id_q;
    pend_data1_d = pend_data1_q;
    pend_data2_d = pend_data2_q;
    cpl_valid_d  = rsp_hit;
    cpl_id_d     = 3'd0;
    cpl_type_d   = 1'b0;
    cpl_data_d   = '0;

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_type_d  = cmd_type;
      pend_id_d    = alloc_id;
      pend_data1_d = cmd_data1;
      pend_data2_d = cmd_data2;
    end else if (issue) begin
      pend_valid_d = 1'b0;
    end

    if (rsp_hit) begin
      cpl_id_d   = output_rsp.rsp_id;
      cpl_type_d = type_q[output_rsp.rsp_id];
      cpl_data_d = output_rsp.rsp_data;
    end

    err_unexp_d   = err_unexp_q | (output_rsp.rsp & ~rsp_hit);
    err_timeout_d = err_timeout_q | (|expire);

    case (state_q)
      S_IDLE: begin
        if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((outstanding_q == 3'd0) && !pend_valid_q && !flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= '0;
      type_q        <= '0;
      pend_valid_q  <= 1'b0;
      pend_type_q   <= 1'b0;
      pend_id_q     <= 3'd0;
      pend_data1_q  <= '0;
      pend_data2_q  <= '0;
      outstanding_q <= 3'd0;
      cpl_valid_q   <= 1'b0;
      cpl_id_q      <= 3'd0;
      cpl_type_q    <= 1'b0;
      cpl_data_q    <= '0;
      err_unexp_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      type_q        <= type_d;
      pend_valid_q  <= pend_valid_d;
      pend_type_q   <= pend_type_d;
      pend_id_q     <= pend_id_d;
      pend_data1_q  <= pend_data1_d;
      pend_data2_q  <= pend_data2_d;
      outstanding_q <= outstanding_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_id_q      <= cpl_id_d;
      cpl_type_q    <= cpl_type_d;
      cpl_data_q    <= cpl_data_d;
      err_unexp_q   <= err_unexp_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Request fields are forced to zero whenever req is low.
  always_comb begin
    input_req = '0;
    if (issue) begin
      input_req.req       = 1'b1;
      input_req.req_type  = pend_type_q;
      input_req.req_id    = pend_id_q;
      input_req.req_data1 = pend_data1_q;
      input_req.req_data2 = pend_data2_q;
    end
  end

  assign cpl_valid   = cpl_valid_q;
  assign cpl_id      = cpl_id_q;
  assign cpl_type    = cpl_type_q;
  assign cpl_data    = cpl_data_q;
  assign outstanding = outstanding_q;
  assign drained     = (state_q == S_DRAIN) && (outstanding_q == 3'd0);
  assign err_unexp   = err_unexp_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_exec_req_initiator.sv
// ---------------------------------------------------------------------------
// tb_exec_req_initiator
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (ID pool as a set of busy flags, one pending entry, drain flag) predicts
// every output each cycle; a few explicit constant checks pin the headline
// scenarios (first issue, backpressure, pool exhaustion, unexpected rsp,
// flush/drain, reset mid-operation).
// ---------------------------------------------------------------------------
module tb_exec_req_initiator;
  import exec_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [31:0] cmd_data1;
  logic [31:0] cmd_data2;
  logic        flush;
  logic        fifo_full;
  req_pkt_type input_req;
  rsp_pkt_type output_rsp;
  logic        cpl_valid;
  logic [2:0]  cpl_id;
  logic        cpl_type;
  logic [63:0] cpl_data;
  logic [2:0]  outstanding;
  logic        drained;
  logic        err_unexp;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_req_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .cmd_data1   (cmd_data1),
    .cmd_data2   (cmd_data2),
    .flush       (flush),
    .fifo_full   (fifo_full),
    .input_req   (input_req),
    .output_rsp  (output_rsp),
    .cpl_valid   (cpl_valid),
    .cpl_id      (cpl_id),
    .cpl_type    (cpl_type),
    .cpl_data    (cpl_data),
    .outstanding (outstanding),
    .drained     (drained),
    .err_unexp   (err_unexp),
    .err_timeout (err_timeout)
  );

  // ---------------- reference model ----------------
  bit        m_busy [8];
  bit        m_type [8];
  bit        m_pend;
  bit        m_pend_type;
  bit [2:0]  m_pend_id;
  bit [31:0] m_pd1;
  bit [31:0] m_pd2;
  bit        m_drain;
  bit        m_cplv;
  bit [2:0]  m_cpl_id;
  bit        m_cpl_type;
  bit [63:0] m_cpl_data;
  bit        m_err;

  function automatic int n_busy();
    int n = 0;
    for (int i = 1; i < 8; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit exp_ready();
    return !rst && !m_drain && !flush && (n_busy() < 7) && (!m_pend || !fifo_full);
  endfunction

  function automatic void model_step();
    int alloc;
    bit acc;
    bit hit;
    int cnt_old;
    bit pend_old;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_busy[i] = 1'b0;
        m_type[i] = 1'b0;
      end
      m_pend = 0; m_pend_type = 0; m_pend_id = 0; m_pd1 = 0; m_pd2 = 0;
      m_drain = 0; m_cplv = 0; m_cpl_id = 0; m_cpl_type = 0; m_cpl_data = 0; m_err = 0;
      return;
    end
    cnt_old  = n_busy();
    pend_old = m_pend;
    acc      = cmd_valid && exp_ready();
    alloc    = 0;
    for (int i = 7; i >= 1; i--) if (!m_busy[i]) alloc = i;
    hit = output_rsp.rsp && (output_rsp.rsp_id != 0) && m_busy[output_rsp.rsp_id];
    m_cplv     = hit;
    m_cpl_id   = hit ? output_rsp.rsp_id : 3'd0;
    m_cpl_type = hit ? m_type[output_rsp.rsp_id] : 1'b0;
    m_cpl_data = hit ? output_rsp.rsp_data : 64'd0;
    if (output_rsp.rsp && !hit) m_err = 1'b1;
    if (hit) m_busy[output_rsp.rsp_id] = 1'b0;
    if (acc) begin
      m_busy[alloc] = 1'b1;
      m_type[alloc] = cmd_type;
      m_pend        = 1'b1;
      m_pend_type   = cmd_type;
      m_pend_id     = 3'(alloc);
      m_pd1         = cmd_data1;
      m_pd2         = cmd_data2;
    end else if (m_pend && !fifo_full) begin
      m_pend = 1'b0;
    end
    if (!m_drain) begin
      if (flush) m_drain = 1'b1;
    end else if (cnt_old == 0 && !pend_old && !flush) begin
      m_drain = 1'b0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rsp(input bit v, input bit [2:0] id, input bit [63:0] d);
    output_rsp.rsp      = v;
    output_rsp.rsp_id   = id;
    output_rsp.rsp_data = d;
  endtask

  // One clock cycle: compare all outputs against the model at the falling
  // edge, advance the model, then move just past the next rising edge.
  task automatic cyc();
    req_pkt_type er;
    @(negedge clk);
    er = '0;
    if (!rst && m_pend && !fifo_full) begin
      er.req       = 1'b1;
      er.req_type  = m_pend_type;
      er.req_id    = m_pend_id;
      er.req_data1 = m_pd1;
      er.req_data2 = m_pd2;
    end
    check("cmd_ready", 128'(cmd_ready), 128'(exp_ready()));
    check("input_req", 128'(input_req), 128'(er));
    check("cpl", 128'({cpl_valid, cpl_id, cpl_type, cpl_data}),
          128'({m_cplv, m_cpl_id, m_cpl_type, m_cpl_data}));
    check("outstanding", 128'(outstanding), 128'(n_busy()));
    check("drained", 128'(drained), 128'(m_drain && n_busy() == 0));
    check("errs", 128'({err_unexp, err_timeout}), 128'({m_err, 1'b0}));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_type = 0; cmd_data1 = 0; cmd_data2 = 0;
    flush = 0; fifo_full = 0; set_rsp(0, 0, 0);
    cyc(); cyc();

    // 1. add 3+4, issue, response, completion
    rst = 0; cmd_valid = 1; cmd_type = 0; cmd_data1 = 3; cmd_data2 = 4;
    settle(); check("t1_ready", 128'(cmd_ready), 128'(1));
    cyc();
    cmd_valid = 0;
    settle(); check("t1_req", 128'({input_req.req, input_req.req_id, input_req.req_data1}),
                    128'({1'b1, 3'd1, 32'd3}));
    cyc();
    set_rsp(1, 1, 64'd7); cyc();
    set_rsp(0, 0, 0);
    settle(); check("t1_cpl", 128'({cpl_valid, cpl_id, cpl_type, cpl_data}),
                    128'({1'b1, 3'd1, 1'b0, 64'd7}));
    cyc();

    // 2. fifo_full backpressure
    fifo_full = 1; cmd_valid = 1; cmd_type = 1; cmd_data1 = 10; cmd_data2 = 20;
    cyc();
    settle(); check("t2_blocked", 128'({cmd_ready, input_req.req}), 128'(0));
    cyc(); cyc();
    fifo_full = 0; cmd_valid = 0;
    settle(); check("t2_issue", 128'({input_req.req, input_req.req_type, input_req.req_id}),
                    128'({1'b1, 1'b1, 3'd1}));
    cyc();
    set_rsp(1, 1, 64'd200); cyc();
    set_rsp(0, 0, 0); cyc();

    // 3. exhaust pool, free id4, reallocation picks id4
    for (int k = 0; k < 7; k++) begin
      cmd_valid = 1; cmd_type = 1'(k); cmd_data1 = 32'(k + 100); cmd_data2 = 32'(k * 2);
      cyc();
    end
    settle(); check("t3_full", 128'({outstanding, cmd_ready}), 128'({3'd7, 1'b0}));
    cyc();
    set_rsp(1, 4, 64'd44); cyc();
    set_rsp(0, 0, 0);
    settle(); check("t3_ready_again", 128'(cmd_ready), 128'(1));
    cyc();
    cmd_valid = 0;
    settle(); check("t3_realloc", 128'({input_req.req, input_req.req_id}), 128'({1'b1, 3'd4}));
    cyc();

    // 4. simultaneous accept + retire, unexpected responses
    set_rsp(1, 5, 64'd55); cyc();
    cmd_valid = 1; cmd_type = 0; cmd_data1 = 7; cmd_data2 = 8; set_rsp(1, 3, 64'd33);
    settle(); check("t4_out_before", 128'(outstanding), 128'(6));
    cyc();
    cmd_valid = 0; set_rsp(0, 0, 0);
    settle(); check("t4_out_after", 128'({outstanding, cpl_valid, cpl_id}), 128'({3'd6, 1'b1, 3'd3}));
    cyc();
    set_rsp(1, 0, 64'd1); cyc();
    set_rsp(0, 0, 0);
    settle(); check("t4_id0", 128'({err_unexp, cpl_valid}), 128'({1'b1, 1'b0}));
    cyc();
    set_rsp(1, 3, 64'd2); cyc();
    set_rsp(0, 0, 0);
    settle(); check("t4_idle_id", 128'({cpl_valid, outstanding}), 128'({1'b0, 3'd6}));
    cyc();
    for (int i = 1; i < 8; i++) begin
      if (m_busy[i]) begin
        set_rsp(1, 3'(i), 64'(i * 1000)); cyc();
      end
    end
    set_rsp(0, 0, 0); cyc();

    // 5. flush with 2 outstanding, drain, return to IDLE
    cmd_valid = 1; cmd_data1 = 1; cmd_data2 = 2; cyc(); cyc();
    cmd_valid = 0; flush = 1;
    settle(); check("t5_ready_low", 128'(cmd_ready), 128'(0));
    cyc(); cyc();
    check("t5_not_drained", 128'({drained, outstanding}), 128'({1'b0, 3'd2}));
    set_rsp(1, 1, 64'd11); cyc();
    set_rsp(1, 2, 64'd22); cyc();
    set_rsp(0, 0, 0); cyc();
    check("t5_drained", 128'(drained), 128'(1));
    flush = 0; cyc();
    settle(); check("t5_idle_ready", 128'(cmd_ready), 128'(1));
    cyc();

    // reset mid-operation; stale response flagged
    cmd_valid = 1; cyc();
    cmd_valid = 0; cyc();
    rst = 1; cyc();
    rst = 0;
    settle(); check("rst_clear", 128'({err_unexp, outstanding, cpl_valid}), 128'(0));
    set_rsp(1, 1, 64'd9); cyc();
    set_rsp(0, 0, 0);
    settle(); check("rst_stale_rsp", 128'({err_unexp, cpl_valid}), 128'({1'b1, 1'b0}));
    cyc();

    // randomized phase
    for (int n = 0; n < 400; n++) begin
      int rid;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_type  = 1'($urandom_range(0, 1));
      cmd_data1 = $urandom;
      cmd_data2 = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) flush = ~flush;
      rid = $urandom_range(1, 7);
      if ($urandom_range(0, 2) == 0 && m_busy[rid] && !(m_pend && m_pend_id == 3'(rid)))
        set_rsp(1, 3'(rid), {$urandom, $urandom});
      else if ($urandom_range(0, 39) == 0)
        set_rsp(1, 3'($urandom_range(0, 7)), 64'(n));
      else
        set_rsp(0, 0, 0);
      cyc();
    end
    flush = 0; cmd_valid = 0; fifo_full = 0; set_rsp(0, 0, 0);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
